qtcore_scan_host: RTL and testbench
===================================

# qtcore_scan_host

Host-side initiator for the qtcore scan/run pin interface. It drives the accumulator microcontroller's clock, scan-enable, processor-enable and scan-in pins, and samples the shared MISO pin. It exchanges a full scan-chain image through byte streams, runs the processor until halt or timeout, and pulses the target's reset. It sits in the test/bring-up FPGA fabric, opposite the qtcore top-level pins.

## Interface
Parameters:
- CHAIN_LEN, 152: scan-chain length in bits; must be ≥ 1.
- CLK_DIV, 2: length of each target-clock phase, in `clk` cycles; must be ≥ 1.
- RUN_MAX, 65535: maximum number of target rising edges during RUN.

Ports:
- clk  in  1  host clock.
- rst  in  1  asynchronous, active-low reset.
- cmd  in  2  command code: 0 SHIFT, 1 RUN, 2 TRESET, 3 NOP.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
- in_data  in  8  scan image byte, consumed LSB-first.
- in_valid  in  1  input byte available.
- in_ready  out  1  one-cycle accept pulse for the input byte.
- out_data  out  8  captured chain byte.
- out_valid  out  1  captured byte pending.
- out_ready  in  1  consumer accepts out_data.
- timeout  out  1  the last RUN hit RUN_MAX; cleared when the next RUN is accepted.
- tgt_clk  out  1  target clock.
- tgt_rst  out  1  target reset, active-high.
- scan_en_n  out  1  target scan enable, active-low.
- proc_en_n  out  1  target processor enable, active-low.
- mosi  out  1  target scan_in.
- miso  in  1  target output: scan_out while scanning, halt while running.

## Operation
- FSM states: IDLE, SH_LOW, SH_HIGH, SH_FLUSH, RUN_LOW, RUN_HIGH, RST_LOW, RST_HIGH.
- Every output is registered.
- Reset values:
  - tgt_clk=0, tgt_rst=0, scan_en_n=1, proc_en_n=1, mosi=0.
  - in_ready=0, out_valid=0, out_data=0, timeout=0, cmd_ready=1.
- SHIFT (IDLE→SH_LOW):
  - scan_en_n=0 for the whole command.
  - Transfers CHAIN_LEN bits as low/high pairs.
  - Low phase:
    - For bit 0 of each byte, wait for in_valid. tgt_clk stays low and the phase timer is frozen while waiting. Pulse in_ready and latch the byte.
    - mosi = the current input bit.
    - In the phase's last cycle, sample miso into the capture byte (LSB-first), then raise tgt_clk.
  - High phase: lasts CLK_DIV cycles, then tgt_clk falls.
  - A capture byte completes after 8 bits or after the final bit; its unused upper bits are 0.
  - The completed byte moves to out_data/out_valid. If out_valid is still high, the next low phase stalls with tgt_clk low.
  - After the last high phase: SH_FLUSH waits for the final out byte to be accepted, then scan_en_n=1 and the FSM returns to IDLE.
  - Byte count in each direction = ceil(CHAIN_LEN/8). Surplus in_data bits are ignored.
  - Net effect: output bytes are the previous chain contents in exit order. The chain then holds the input image.
- RUN (IDLE→RUN_LOW):
  - proc_en_n=0, timeout cleared.
  - Each low phase samples miso in its last cycle:
    - If miso=1 (halted): no further rising edge, proc_en_n=1, return to IDLE.
    - If miso=0: raise tgt_clk and increment the edge counter (width $clog2(RUN_MAX+1)).
  - After RUN_MAX rising edges without halt: timeout=1, proc_en_n=1, return to IDLE.
- TRESET: tgt_rst=1 for 4 full target-clock periods with scan_en_n=1 and proc_en_n=1, then tgt_rst=0 and return to IDLE.
- NOP: accepted, no pin activity; cmd_ready is high again the next cycle.
- scan_en_n and proc_en_n are never low simultaneously.
- Commands are ignored unless in IDLE.
- Reset mid-operation: all outputs go to their reset values immediately. Partial bytes are discarded. Target chain contents are undefined; the bench must re-SHIFT afterwards.

## Timing
- Command accepted at edge T0.
- At T0+1: scan_en_n or proc_en_n asserts, and the first low phase starts.
- First tgt_clk rise: T0+1+CLK_DIV, assuming no stalls.
- One target clock period = 2·CLK_DIV `clk` cycles.
- An unstalled SHIFT reaches IDLE at T0+1+2·CLK_DIV·CHAIN_LEN+1.
- mosi changes only while tgt_clk is low, at least CLK_DIV cycles before the rise.
- in_ready is a single-cycle pulse. out_valid holds until out_ready.
- tgt_clk is glitch-free and always ends low in IDLE.

## Structure
- Package qtcore_scan_pkg holds:
  - command encodings: CMD_SHIFT, CMD_RUN, CMD_TRESET, CMD_NOP;
  - the state enum;
  - TRESET_PERIODS=4.
- Sub-module scan_phase_timer:
  - counts CLK_DIV;
  - has a freeze input;
  - emits a phase_end pulse.
- The FSM, bit counter, byte counter, edge counter and byte registers live in qtcore_scan_host.

## Test plan
Bench setup: CHAIN_LEN=12, CLK_DIV=1, RUN_MAX=20, plus a behavioural qtcore model (12-bit shift chain, halt flag).
- Reset: assert rst mid-idle → all outputs at reset values, cmd_ready=1.
- SHIFT, model chain preloaded with exit order 0xBC,0x0A; feed 0x5A,0x03 → out 0xBC,0x0A; exactly 12 tgt_clk rises. A second SHIFT with 0x00,0x00 → out 0x5A,0x03.
- Backpressure: hold out_ready=0 for 10 cycles after the first byte → no tgt_clk rise during the stall; the transfer completes correctly afterwards. Also withhold in_valid → tgt_clk stays low.
- RUN, model halts after 5 edges → exactly 5 rises, proc_en_n=1, timeout=0. Halt already high → 0 rises.
- RUN, model never halts → exactly 20 rises, timeout=1. A following RUN clears timeout on accept.
- Reset mid-SHIFT (after 7 bits) → scan_en_n=1 and tgt_clk=0 immediately, out_valid=0. A fresh SHIFT then works.

Source files
------------

// File: rtl/qtcore_scan_pkg.sv
// Shared encodings and helpers for the qtcore scan/run host.
package qtcore_scan_pkg;

    typedef enum logic [1:0] {
        CMD_SHIFT  = 2'd0,
        CMD_RUN    = 2'd1,
        CMD_TRESET = 2'd2,
        CMD_NOP    = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SH_LOW   = 3'd1,
        SH_HIGH  = 3'd2,
        SH_FLUSH = 3'd3,
        RUN_LOW  = 3'd4,
        RUN_HIGH = 3'd5,
        RST_LOW  = 3'd6,
        RST_HIGH = 3'd7
    } state_e;

    localparam int unsigned TRESET_PERIODS = 4;
    localparam int unsigned TRESET_CW      = $clog2(TRESET_PERIODS);

    // Return b with bit idx replaced by v.
    function automatic logic [7:0] set_bit8(input logic [7:0] b, input logic [2:0] idx,
                                            input logic v);
        logic [7:0] r;
        r      = b;
        r[idx] = v;
        return r;
    endfunction

endpackage

// File: rtl/qtcore_scan_host_timer.sv
// Target-clock phase timer: counts CLK_DIV host cycles per phase, holds while frozen.
module scan_phase_timer #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic freeze_i,
    output logic phase_end_c
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign phase_end_c = !clr_i && !freeze_i && (cnt_q == CW'(CLK_DIV - 1));

    // Phase counter wraps at every phase end so back-to-back phases need no restart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (!freeze_i) begin
            cnt_q <= phase_end_c ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/qtcore_scan_host.sv
// Host-side initiator for the qtcore scan/run pins: chain exchange, run-to-halt, target reset.
module qtcore_scan_host
    import qtcore_scan_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 152,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned RUN_MAX   = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       timeout,
    output logic       tgt_clk,
    output logic       tgt_rst,
    output logic       scan_en_n,
    output logic       proc_en_n,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int unsigned EW = (RUN_MAX > 0) ? $clog2(RUN_MAX + 1) : 1;

    state_e                 state_q;
    logic                   first_q;
    logic                   have_byte_q;
    logic [7:0]             byte_q;
    logic [7:0]             cap_q;
    logic [2:0]             bib_q;
    logic [BW-1:0]          bit_cnt_q;
    logic [EW-1:0]          edge_cnt_q;
    logic [TRESET_CW-1:0]   per_cnt_q;

    logic       cmd_ready_q;
    logic       in_ready_q;
    logic [7:0] out_data_q;
    logic       out_valid_q;
    logic       timeout_q;
    logic       tgt_clk_q;
    logic       tgt_rst_q;
    logic       scan_en_n_q;
    logic       proc_en_n_q;
    logic       mosi_q;

    logic       last_bit_c;
    logic       byte_done_c;
    logic [7:0] cap_next_c;
    logic       timer_clr_c;
    logic       freeze_c;
    logic       phase_end_c;

    // Phase timing; low phases freeze on the start cycle, a missing input byte or a full output slot.
    scan_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (timer_clr_c),
        .freeze_i   (freeze_c),
        .phase_end_c(phase_end_c)
    );

    // Shift-position decode and timer control.
    always_comb begin
        last_bit_c  = (bit_cnt_q == BW'(CHAIN_LEN - 1));
        byte_done_c = last_bit_c || (bib_q == 3'd7);
        cap_next_c  = set_bit8(cap_q, bib_q, miso);
        timer_clr_c = (state_q == IDLE);
        freeze_c    = first_q || (state_q == IDLE) || (state_q == SH_FLUSH) ||
                      ((state_q == SH_LOW) && (!have_byte_q || out_valid_q));
    end

    // Command FSM with all pin and stream outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            first_q     <= 1'b0;
            have_byte_q <= 1'b0;
            byte_q      <= '0;
            cap_q       <= '0;
            bib_q       <= '0;
            bit_cnt_q   <= '0;
            edge_cnt_q  <= '0;
            per_cnt_q   <= '0;
            cmd_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            tgt_clk_q   <= 1'b0;
            tgt_rst_q   <= 1'b0;
            scan_en_n_q <= 1'b1;
            proc_en_n_q <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            in_ready_q <= 1'b0;
            first_q    <= 1'b0;
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        case (cmd_e'(cmd))
                            CMD_SHIFT: begin
                                state_q     <= SH_LOW;
                                first_q     <= 1'b1;
                                scan_en_n_q <= 1'b0;
                                bit_cnt_q   <= '0;
                                bib_q       <= '0;
                                have_byte_q <= 1'b0;
                                cap_q       <= '0;
                            end
                            CMD_RUN: begin
                                state_q     <= RUN_LOW;
                                first_q     <= 1'b1;
                                proc_en_n_q <= 1'b0;
                                timeout_q   <= 1'b0;
                                edge_cnt_q  <= '0;
                            end
                            CMD_TRESET: begin
                                state_q   <= RST_LOW;
                                first_q   <= 1'b1;
                                tgt_rst_q <= 1'b1;
                                per_cnt_q <= '0;
                            end
                            default: ;
                        endcase
                    end
                end

                SH_LOW: begin
                    if (!have_byte_q) begin
                        if (in_valid) begin
                            byte_q      <= in_data;
                            have_byte_q <= 1'b1;
                            in_ready_q  <= 1'b1;
                            mosi_q      <= in_data[0];
                        end
                    end else if (phase_end_c) begin
                        tgt_clk_q <= 1'b1;
                        state_q   <= SH_HIGH;
                        if (byte_done_c) begin
                            out_data_q  <= cap_next_c;
                            out_valid_q <= 1'b1;
                            cap_q       <= '0;
                        end else begin
                            cap_q <= cap_next_c;
                        end
                    end
                end

                SH_HIGH: begin
                    if (phase_end_c) begin
                        tgt_clk_q <= 1'b0;
                        if (last_bit_c) begin
                            state_q <= SH_FLUSH;
                            mosi_q  <= 1'b0;
                        end else begin
                            state_q   <= SH_LOW;
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            bib_q     <= bib_q + 3'd1;
                            if (bib_q == 3'd7) begin
                                // Next byte is taken at the falling edge when already offered.
                                have_byte_q <= 1'b0;
                                if (in_valid) begin
                                    byte_q      <= in_data;
                                    have_byte_q <= 1'b1;
                                    in_ready_q  <= 1'b1;
                                    mosi_q      <= in_data[0];
                                end
                            end else begin
                                mosi_q <= byte_q[bib_q + 3'd1];
                            end
                        end
                    end
                end

                SH_FLUSH: begin
                    if (!out_valid_q || out_ready) begin
                        scan_en_n_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                RUN_LOW: begin
                    if (phase_end_c) begin
                        if (miso) begin
                            proc_en_n_q <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            tgt_clk_q  <= 1'b1;
                            edge_cnt_q <= edge_cnt_q + EW'(1);
                            state_q    <= RUN_HIGH;
                        end
                    end
                end

                RUN_HIGH: begin
                    if (phase_end_c) begin
                        tgt_clk_q <= 1'b0;
                        if (edge_cnt_q == EW'(RUN_MAX)) begin
                            timeout_q   <= 1'b1;
                            proc_en_n_q <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= RUN_LOW;
                        end
                    end
                end

                RST_LOW: begin
                    if (phase_end_c) begin
                        tgt_clk_q <= 1'b1;
                        state_q   <= RST_HIGH;
                    end
                end

                RST_HIGH: begin
                    if (phase_end_c) begin
                        tgt_clk_q <= 1'b0;
                        if (per_cnt_q == TRESET_CW'(TRESET_PERIODS - 1)) begin
                            tgt_rst_q   <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            per_cnt_q <= per_cnt_q + TRESET_CW'(1);
                            state_q   <= RST_LOW;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign timeout   = timeout_q;
    assign tgt_clk   = tgt_clk_q;
    assign tgt_rst   = tgt_rst_q;
    assign scan_en_n = scan_en_n_q;
    assign proc_en_n = proc_en_n_q;
    assign mosi      = mosi_q;

endmodule

// File: tb/tb_qtcore_scan_host.sv
// Directed bench for qtcore_scan_host with a behavioural 12-bit qtcore chain/halt model.
module tb_qtcore_scan_host;
    import qtcore_scan_pkg::*;

    localparam int unsigned CL = 12;
    localparam int unsigned CD = 1;
    localparam int unsigned RM = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       timeout;
    logic       tgt_clk;
    logic       tgt_rst;
    logic       scan_en_n;
    logic       proc_en_n;
    logic       mosi;
    logic       miso;

    int n_tests = 0;
    int n_fail  = 0;

    qtcore_scan_host #(
        .CHAIN_LEN(CL),
        .CLK_DIV  (CD),
        .RUN_MAX  (RM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .timeout  (timeout),
        .tgt_clk  (tgt_clk),
        .tgt_rst  (tgt_rst),
        .scan_en_n(scan_en_n),
        .proc_en_n(proc_en_n),
        .mosi     (mosi),
        .miso     (miso)
    );

    always #5 clk = ~clk;

    // qtcore model: scan chain exits from bit 0, halt raised after halt_at run edges.
    logic [11:0] chain = 12'hABC;
    int          rises = 0;
    int          run_base;
    int          halt_at;

    always @(posedge tgt_clk) begin
        rises = rises + 1;
        if (!scan_en_n) chain = {mosi, chain[11:1]};
    end

    assign miso = scan_en_n ? ((rises - run_base) >= halt_at) : chain[0];

    // Byte source: advances on each in_ready pulse.
    logic [7:0] feed_b [2];
    logic       feed_en;
    logic       feed_rst;
    int         in_idx = 0;

    always @(negedge clk) begin
        if (feed_rst) in_idx = 0;
        else if (in_ready && in_valid) in_idx = in_idx + 1;
        in_valid = feed_en && (in_idx < 2);
        in_data  = in_valid ? feed_b[in_idx] : 8'h00;
    end

    // Byte sink: records every accepted output byte.
    logic [7:0] got [32];
    int         out_cnt = 0;

    always @(posedge clk) begin
        if (rst && out_valid && out_ready) begin
            got[out_cnt % 32] = out_data;
            out_cnt = out_cnt + 1;
        end
    end

    int out_base;
    int rise_base;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_tests = n_tests + 1;
        if (got_v !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic wait_idle(input string tag, input int max_cyc, output int lat);
        bit done;
        int i;
        done = 1'b0;
        lat  = 0;
        i    = 0;
        while (!done && i < max_cyc) begin
            @(posedge clk);
            #1;
            i = i + 1;
            if (cmd_ready) begin
                done = 1'b1;
                lat  = i;
            end
        end
        check({tag, "_idle"}, 32'(done), 32'd1);
    endtask

    task automatic issue(input logic [1:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic start_shift(input logic [7:0] b0, input logic [7:0] b1, input bit feed);
        @(posedge clk);
        #1;
        feed_b[0] = b0;
        feed_b[1] = b1;
        feed_rst  = 1'b1;
        feed_en   = feed;
        @(posedge clk);
        #1;
        feed_rst  = 1'b0;
        out_base  = out_cnt;
        rise_base = rises;
        issue(CMD_SHIFT);
    endtask

    task automatic end_shift(input string tag, input bit chk_data, input logic [7:0] e0,
                             input logic [7:0] e1, input int exp_lat);
        int lat;
        wait_idle(tag, 400, lat);
        check({tag, "_nbytes"}, 32'(out_cnt - out_base), 32'd2);
        if (chk_data) begin
            check({tag, "_byte0"}, 32'(got[out_base % 32]), 32'(e0));
            check({tag, "_byte1"}, 32'(got[(out_base + 1) % 32]), 32'(e1));
        end
        check({tag, "_rises"}, 32'(rises - rise_base), 32'(CL));
        check({tag, "_scan_en_n"}, 32'(scan_en_n), 32'd1);
        if (exp_lat > 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic do_run(input string tag, input int h, input int exp_rises, input bit exp_to);
        int lat;
        halt_at  = h;
        run_base = rises;
        issue(CMD_RUN);
        check({tag, "_timeout_on_accept"}, 32'(timeout), 32'd0);
        check({tag, "_proc_en_n_on"}, 32'(proc_en_n), 32'd0);
        check({tag, "_scan_en_n_off"}, 32'(scan_en_n), 32'd1);
        wait_idle(tag, 200, lat);
        check({tag, "_rises"}, 32'(rises - run_base), 32'(exp_rises));
        check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
        check({tag, "_proc_en_n_off"}, 32'(proc_en_n), 32'd1);
        check({tag, "_tgt_clk_low"}, 32'(tgt_clk), 32'd0);
    endtask

    initial begin
        int lat;
        int r;
        bit seen;
        rst       = 1'b0;
        cmd       = CMD_NOP;
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        feed_en   = 1'b0;
        feed_rst  = 1'b1;
        feed_b[0] = 8'h00;
        feed_b[1] = 8'h00;
        halt_at   = 0;
        run_base  = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready", 32'(cmd_ready), 32'd1);

        // NOP: one-cycle ready drop, no target clocking.
        r = rises;
        issue(CMD_NOP);
        check("nop_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        check("nop_ready_back", 32'(cmd_ready), 32'd1);
        check("nop_no_clk", 32'(rises - r), 32'd0);

        // Reset asserted while idle.
        #3 rst = 1'b0;
        #1;
        check("rst_pins", {27'd0, tgt_clk, tgt_rst, scan_en_n, proc_en_n, mosi}, 32'b00110);
        check("rst_stream", {22'd0, in_ready, out_valid, out_data}, 32'd0);
        check("rst_ready_to", {30'd0, cmd_ready, timeout}, 32'b10);
        @(posedge clk);
        #1 rst = 1'b1;

        // Chain exchange: preload ABC exits BC,0A; then image 35A exits 5A,03.
        start_shift(8'h5A, 8'h03, 1'b1);
        end_shift("shift1", 1'b1, 8'hBC, 8'h0A, 1 + 2 * CD * CL + 1);
        start_shift(8'h00, 8'h00, 1'b1);
        end_shift("shift2", 1'b1, 8'h5A, 8'h03, 1 + 2 * CD * CL + 1);

        // Input withheld: target clock must stay low.
        start_shift(8'h34, 8'h0C, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("nodata_rises", 32'(rises - rise_base), 32'd0);
        check("nodata_tgt_clk", 32'(tgt_clk), 32'd0);
        check("nodata_scan_en_n", 32'(scan_en_n), 32'd0);
        feed_en = 1'b1;
        end_shift("nodata", 1'b1, 8'h00, 8'h00, 0);

        // Output backpressure: no rise while the first byte is pending.
        out_ready = 1'b0;
        start_shift(8'hF1, 8'hF7, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = out_valid;
        end
        check("stall_first_byte_seen", 32'(seen), 32'd1);
        r = rises;
        repeat (10) @(posedge clk);
        #1;
        check("stall_rises", 32'(rises - r), 32'd0);
        check("stall_tgt_clk", 32'(tgt_clk), 32'd0);
        check("stall_out_data", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h34});
        out_ready = 1'b1;
        end_shift("stall", 1'b1, 8'h34, 8'h0C, 0);

        // Surplus input bits of the last byte are dropped; unused capture bits read 0.
        start_shift(8'h00, 8'h00, 1'b1);
        end_shift("surplus", 1'b1, 8'hF1, 8'h07, 0);

        // Run to halt, halt already set, timeout, and timeout clear on next accept.
        do_run("run_halt5", 5, 5, 1'b0);
        do_run("run_halt0", 0, 0, 1'b0);
        do_run("run_timeout", 1000, RM, 1'b1);
        do_run("run_after_to", 0, 0, 1'b0);

        // Target reset: four full target-clock periods.
        r = rises;
        issue(CMD_TRESET);
        check("treset_rst_on", {29'd0, tgt_rst, scan_en_n, proc_en_n}, 32'b111);
        wait_idle("treset", 100, lat);
        check("treset_rises", 32'(rises - r), 32'(TRESET_PERIODS));
        check("treset_rst_off", 32'(tgt_rst), 32'd0);

        // Host reset after 7 bits of a SHIFT.
        start_shift(8'hAA, 8'h55, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = (rises - rise_base) >= 7;
        end
        check("midrst_reached7", 32'(seen), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_pins", {29'd0, scan_en_n, tgt_clk, out_valid}, 32'b100);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        feed_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        start_shift(8'h5A, 8'h03, 1'b1);
        end_shift("post_rst1", 1'b0, 8'h00, 8'h00, 1 + 2 * CD * CL + 1);
        start_shift(8'h00, 8'h00, 1'b1);
        end_shift("post_rst2", 1'b1, 8'h5A, 8'h03, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
